// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared definitions for the immediate extend unit: the mode
//               encoding driven by the decoder and the prefix FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

  // Mode encoding on the mode port. Codes 5..7 are reserved and decode as SEXT.
  localparam logic [2:0] IMM_SEXT   = 3'd0;
  localparam logic [2:0] IMM_ZEXT   = 3'd1;
  localparam logic [2:0] IMM_SHL1   = 3'd2;
  localparam logic [2:0] IMM_LUI    = 3'd3;
  localparam logic [2:0] IMM_PREFIX = 3'd4;

  // NOPFX: no upper bits pending. PFX: a PREFIX op has loaded the prefix
  // register and the next non-PREFIX immediate consumes it.
  typedef enum logic [0:0] {
    ST_NOPFX = 1'b0,
    ST_PFX   = 1'b1
  } pfx_state_t;

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Purely combinational datapath of the immediate extend unit.
//               Masks the variable-width field, applies sign/zero fill or
//               merges a pending prefix, then applies SHL1 / LUI shaping.
// Ports       : imm_i      - raw field, LSB-aligned
//               field_w    - active field width (0 means IN_W)
//               mode       - operation code (see imm_pkg)
//               pfx_active - a prefix is pending
//               pfx_val    - pending prefix bits
//               result     - extended immediate
//               ovf        - SHL1 shifted out a significant bit
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
  import imm_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int IN_W   = 8,
  localparam int PFX_W  = DATA_W - IN_W,
  localparam int FW_W   = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]   imm_i,
  input  logic [FW_W-1:0]   field_w,
  input  logic [2:0]        mode,
  input  logic              pfx_active,
  input  logic [PFX_W-1:0]  pfx_val,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  localparam logic [FW_W-1:0] FW_MAX = FW_W'(IN_W);

  logic [FW_W-1:0]   w_fw_eff;
  logic [IN_W-1:0]   w_keep_mask;
  logic [IN_W-1:0]   w_sign_sel;
  logic [IN_W-1:0]   w_masked;
  logic              w_sign_bit;
  logic              w_fill_bit;
  logic [DATA_W-1:0] w_ext;

  always_comb begin
    // Width 0 selects the full field; out-of-range widths saturate to IN_W.
    w_fw_eff    = ((field_w == '0) || (field_w > FW_MAX)) ? FW_MAX : field_w;
    // Ones below the effective width; a shift by IN_W yields an all-ones mask.
    w_keep_mask = ~({IN_W{1'b1}} << w_fw_eff);
    // One-hot select of bit fw-1 avoids a variable part-select on imm_i.
    w_sign_sel  = IN_W'(1) << (w_fw_eff - 1'b1);
    w_masked    = imm_i & w_keep_mask;
    w_sign_bit  = |(imm_i & w_sign_sel);
    w_fill_bit  = (mode == IMM_ZEXT) ? 1'b0 : w_sign_bit;

    if (pfx_active) begin
      // Prefix supplies every bit above the field; the field is zero-filled
      // up to IN_W so the two halves concatenate cleanly.
      w_ext = {pfx_val, w_masked};
    end else begin
      w_ext = {{PFX_W{w_fill_bit}}, w_masked | ({IN_W{w_fill_bit}} & ~w_keep_mask)};
    end

    result = w_ext;
    ovf    = 1'b0;
    case (mode)
      IMM_SHL1: begin
        result = {w_ext[DATA_W-2:0], 1'b0};
        // The new MSB differs from the old one: the signed value changed.
        ovf    = w_ext[DATA_W-1] ^ w_ext[DATA_W-2];
      end
      IMM_LUI: begin
        result = {imm_i, {PFX_W{1'b0}}};
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_unit
// Description : Registered, valid/ready immediate generator between the
//               decoder and the ALU operand mux. Supports SEXT, ZEXT, SHL1,
//               LUI and PREFIX (two-instruction full-width constants).
// Ports       : clk, rst_n (async active-low), flush (sync clear)
//               in_valid/in_ready   - request handshake
//               imm_i, field_w, mode - request payload
//               out_valid/out_ready - result handshake
//               imm_o, ovf_o         - result payload (qualified by out_valid)
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_unit
  import imm_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int IN_W   = 8,
  localparam int PFX_W  = DATA_W - IN_W,
  localparam int FW_W   = $clog2(IN_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   imm_i,
  input  logic [FW_W-1:0]   field_w,
  input  logic [2:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_o,
  output logic              ovf_o
);

  pfx_state_t        r_state;
  logic [PFX_W-1:0]  r_pfx;
  logic [PFX_W-1:0]  w_pfx_load;
  logic [DATA_W-1:0] w_result;
  logic              w_ovf;
  logic              w_accept;

  // The output register can take new data whenever it is empty or is being
  // drained this cycle, giving full throughput under continuous flow.
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Prefix payload: zero-extend or truncate the raw field to PFX_W.
  if (PFX_W > IN_W) begin : g_pfx_zext
    assign w_pfx_load = {{(PFX_W - IN_W){1'b0}}, imm_i};
  end else begin : g_pfx_trunc
    assign w_pfx_load = imm_i[PFX_W-1:0];
  end

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IN_W   (IN_W)
  ) u_core (
    .imm_i      (imm_i),
    .field_w    (field_w),
    .mode       (mode),
    .pfx_active (r_state == ST_PFX),
    .pfx_val    (r_pfx),
    .result     (w_result),
    .ovf        (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_NOPFX;
      r_pfx     <= '0;
      out_valid <= 1'b0;
      imm_o     <= '0;
      ovf_o     <= 1'b0;
    end else if (flush) begin
      // Flush wins over a same-cycle request, which is silently dropped.
      r_state   <= ST_NOPFX;
      r_pfx     <= '0;
      out_valid <= 1'b0;
    end else if (w_accept && (mode == IMM_PREFIX)) begin
      // No result is produced; a result already held only leaves via drain.
      r_state   <= ST_PFX;
      r_pfx     <= w_pfx_load;
      out_valid <= out_valid && !out_ready;
    end else if (w_accept) begin
      // Every non-PREFIX op consumes (LUI discards) any pending prefix.
      r_state   <= ST_NOPFX;
      r_pfx     <= '0;
      out_valid <= 1'b1;
      imm_o     <= w_result;
      ovf_o     <= w_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
